// File: rtl/imem_boot_sequencer_pkg.sv
// Shared definitions for the instruction-memory boot sequencer: FSM states,
// protocol byte defaults and a helper telling which states talk to the UART tx.
package imem_boot_sequencer_pkg;

    typedef enum logic [2:0] {
        S_HELLO,
        S_SIZE,
        S_LOAD,
        S_ERR,
        S_ACK,
        S_RUN
    } state_e;

    localparam logic [7:0] HELLO_BYTE_DEF = 8'h99;
    localparam logic [7:0] ACK_BYTE_DEF   = 8'hAA;
    localparam logic [7:0] ERR_BYTE_DEF   = 8'hEE;

    function automatic logic isTxState(input state_e s);
        case (s)
            S_HELLO, S_ERR, S_ACK: return 1'b1;
            default:               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/imem_boot_sequencer_byte_word_assembler.sv
// Collects UART bytes into big-endian 32-bit words. The first byte of a group
// ends up in bits [31:24]; word_valid_o pulses on the cycle the 4th byte arrives.
module byte_word_assembler (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [23:0] shift_q, shift_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;

    // Next-state for the shift register and the wrapping 2-bit byte counter.
    always_comb begin
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        if (clear_i) begin
            shift_d    = '0;
            byte_cnt_d = '0;
        end else if (byte_valid_i) begin
            shift_d    = {shift_q[15:0], byte_data_i};
            byte_cnt_d = byte_cnt_q + 2'd1;
        end
    end

    // Holds the partially assembled word across bytes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_q    <= '0;
            byte_cnt_q <= '0;
        end else begin
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    assign word_o       = {shift_q, byte_data_i};
    assign word_valid_o = byte_valid_i && !clear_i && (byte_cnt_q == 2'd3);

endmodule

// File: rtl/imem_boot_sequencer.sv
// Boot sequencer owning the instruction-memory port: greets the host over UART,
// loads a size-prefixed program into BRAM, then releases the core and hands the
// BRAM port to the fetch stage. A reload request in run returns to the greeting.
module imem_boot_sequencer
    import imem_boot_sequencer_pkg::*;
#(
    parameter int         ADDR_W     = 15,
    parameter logic [7:0] HELLO_BYTE = HELLO_BYTE_DEF,
    parameter logic [7:0] ACK_BYTE   = ACK_BYTE_DEF,
    parameter logic [7:0] ERR_BYTE   = ERR_BYTE_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              tx_ready,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              reload_req,
    input  logic [31:0]       fetch_addr,
    output logic [31:0]       fetch_instr,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_we,
    output logic [31:0]       imem_wdata,
    input  logic [31:0]       imem_rdata,
    output logic              core_reset,
    output logic              running
);

    localparam logic [31:0] CAPACITY = 32'd1 << ADDR_W;

    state_e              state_q, state_d;
    logic [31:0]         size_q, size_d;
    logic [ADDR_W:0]     word_cnt_q, word_cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   load_addr_q, load_addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                tx_valid_q, tx_valid_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                core_reset_q, core_reset_d;

    logic                asmClear;
    logic                asmValid;
    logic [31:0]         asmWord;
    logic                asmWordValid;
    logic                unusedFetchBits;

    byte_word_assembler u_assembler (
        .clock        (clock),
        .reset        (reset),
        .clear_i      (asmClear),
        .byte_valid_i (asmValid),
        .byte_data_i  (rx_data),
        .word_o       (asmWord),
        .word_valid_o (asmWordValid)
    );

    // Next-state logic: header parsing, payload writes, tx handshakes, reload.
    always_comb begin
        state_d      = state_q;
        size_d       = size_q;
        word_cnt_d   = word_cnt_q;
        we_d         = 1'b0;
        load_addr_d  = load_addr_q;
        wdata_d      = wdata_q;
        asmClear     = 1'b1;
        asmValid     = 1'b0;
        case (state_q)
            S_HELLO: begin
                if (tx_valid_q && tx_ready) state_d = S_SIZE;
            end
            S_SIZE: begin
                asmClear = 1'b0;
                asmValid = rx_valid;
                if (asmWordValid) begin
                    size_d     = asmWord;
                    word_cnt_d = '0;
                    if (asmWord > CAPACITY)   state_d = S_ERR;
                    else if (asmWord == '0)   state_d = S_ACK;
                    else                      state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                asmClear = 1'b0;
                asmValid = rx_valid;
                if (asmWordValid) begin
                    we_d        = 1'b1;
                    load_addr_d = word_cnt_q[ADDR_W-1:0];
                    wdata_d     = asmWord;
                    word_cnt_d  = word_cnt_q + {{ADDR_W{1'b0}}, 1'b1};
                    if ({{(31-ADDR_W){1'b0}}, word_cnt_d} == size_q) state_d = S_ACK;
                end
            end
            S_ERR: begin
                if (tx_valid_q && tx_ready) state_d = S_SIZE;
            end
            S_ACK: begin
                if (tx_valid_q && tx_ready) state_d = S_RUN;
            end
            S_RUN: begin
                if (reload_req) begin
                    state_d    = S_HELLO;
                    size_d     = '0;
                    word_cnt_d = '0;
                end
            end
            default: state_d = S_HELLO;
        endcase
    end

    // Tx offer is registered from the upcoming state so data stays stable until accepted.
    always_comb begin
        tx_valid_d = isTxState(state_d);
        tx_data_d  = 8'h00;
        case (state_d)
            S_HELLO: tx_data_d = HELLO_BYTE;
            S_ERR:   tx_data_d = ERR_BYTE;
            S_ACK:   tx_data_d = ACK_BYTE;
            default: tx_data_d = 8'h00;
        endcase
        core_reset_d = (state_q != S_RUN) || reload_req;
    end

    // State and datapath registers; reset parks everything in the greeting state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_HELLO;
            size_q       <= '0;
            word_cnt_q   <= '0;
            we_q         <= 1'b0;
            load_addr_q  <= '0;
            wdata_q      <= '0;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= '0;
            core_reset_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            size_q       <= size_d;
            word_cnt_q   <= word_cnt_d;
            we_q         <= we_d;
            load_addr_q  <= load_addr_d;
            wdata_q      <= wdata_d;
            tx_valid_q   <= tx_valid_d;
            tx_data_q    <= tx_data_d;
            core_reset_q <= core_reset_d;
        end
    end

    assign running         = (state_q == S_RUN);
    assign imem_addr       = running ? fetch_addr[ADDR_W-1:0] : load_addr_q;
    assign imem_we         = we_q && !running;
    assign imem_wdata      = wdata_q;
    assign fetch_instr     = running ? imem_rdata : 32'h0;
    assign tx_valid        = tx_valid_q;
    assign tx_data         = tx_data_q;
    assign core_reset      = core_reset_q;
    assign unusedFetchBits = ^fetch_addr[31:ADDR_W];

endmodule

// File: doc/imem_boot_sequencer.md
Name: imem_boot_sequencer

Overview:
- Owns the single instruction-memory port at boot and during reload; the fetch stage gets the port once loading has finished.
- Loads a program from the UART byte stream into instruction memory.
- Holds the core in reset while loading; hands the port to the fetch stage when loading completes.
- Sits between the UART rx/tx pair, the instruction BRAM and InstructionFetch (the core's instr_mem master).

Parameters:
- ADDR_W, 15, word-address width of instruction memory; fetch uses the low 15 bits of its 16-bit PC.
- HELLO_BYTE, 8'h99, byte sent when the sequencer is ready for a program.
- ACK_BYTE, 8'hAA, byte sent after the last word is written.
- ERR_BYTE, 8'hEE, byte sent when the size header exceeds capacity.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- rx_valid  in  1  one-cycle pulse: rx_data holds a received byte
- rx_data  in  8  received byte
- tx_ready  in  1  transmitter can accept a byte
- tx_valid  out  1  byte offer to transmitter
- tx_data  out  8  byte to send
- reload_req  in  1  pulse: abandon the run and reload a program
- fetch_addr  in  32  instruction address from fetch (instr_mem.addr)
- fetch_instr  out  32  instruction to fetch (instr_mem.instr)
- imem_addr  out  ADDR_W  BRAM address
- imem_we  out  1  BRAM write enable
- imem_wdata  out  32  BRAM write data
- imem_rdata  in  32  BRAM read data, 1-cycle latency
- core_reset  out  1  reset to the rest of the core
- running  out  1  high in S_RUN

Behaviour:
- Reset (async, any state): state=S_HELLO, byte_cnt=0, word_cnt=0, size=0, tx_valid=0, imem_we=0, core_reset=1, running=0.
- S_HELLO:
  - tx_valid=1, tx_data=HELLO_BYTE.
  - On tx_valid&tx_ready go to S_SIZE.
  - rx bytes in this state are dropped.
- S_SIZE:
  - Assemble 4 bytes big-endian; the first byte is bits [31:24]. The result is size, in words.
  - After the 4th byte:
    - size > 2**ADDR_W: go to S_ERR.
    - size == 0: go to S_ACK.
    - otherwise: go to S_LOAD.
  - byte_cnt clears on every exit.
- S_LOAD:
  - Assemble words big-endian.
  - On the cycle the 4th byte arrives, register imem_we=1 for exactly one cycle, with imem_addr=word_cnt[ADDR_W-1:0] and imem_wdata=the assembled word. Then increment word_cnt.
  - Once word_cnt reaches size (the write of word size-1 has been issued), go to S_ACK.
  - Back-to-back rx_valid on consecutive cycles must work; there are no lost bytes.
- S_ERR: tx ERR_BYTE (same handshake as HELLO), then S_SIZE.
- S_ACK: tx ACK_BYTE, then S_RUN.
- S_RUN:
  - core_reset=0, running=1.
  - imem_addr=fetch_addr[ADDR_W-1:0] (combinational pass-through), imem_we=0, fetch_instr=imem_rdata.
  - rx bytes are ignored.
- Outside S_RUN: imem_addr is driven by the loader; fetch_instr=32'h0 (treated as a bubble).
- core_reset:
  - Is registered.
  - Drops on the cycle after S_RUN is entered.
  - Rises the cycle after reload_req is seen.
  - The core's first fetch after release is therefore addr 0, with one BRAM cycle of latency.
- reload_req:
  - Honoured only in S_RUN; ignored elsewhere.
  - Goes to S_HELLO and clears all counters.
- tx_valid is held until tx_ready; tx_data is stable while tx_valid=1.
- Counters: byte_cnt is 2 bits and wraps. word_cnt is ADDR_W+1 bits, so it can reach size=2**ADDR_W.
- A word is written only on a complete 4-byte group.

Decomposition:
- Shared package: state enum (S_HELLO, S_SIZE, S_LOAD, S_ERR, S_ACK, S_RUN) and the HELLO/ACK/ERR byte constants.
- One sub-module, byte_word_assembler:
  - Shift-in of bytes, 2-bit counter, word_valid pulse.
  - Clear input.
  - Reused for both the size header and the payload.
- Port mux and FSM stay in the top.

Test Plan:
- Reset release:
  - tx shows 0x99 until tx_ready; core_reset=1 throughout; fetch_instr=0.
- Size 2, words 0xDEADBEEF, 0x12345678:
  - Bytes 00 00 00 02 DE AD BE EF 12 34 56 78.
  - imem_we pulses at addr 0 (0xDEADBEEF), then addr 1 (0x12345678).
  - Then tx 0xAA; core_reset falls one cycle after S_RUN is entered.
- Size 0:
  - Bytes 00 00 00 00 go straight to 0xAA with no imem_we.
- Size 0x00008001:
  - tx 0xEE, back to S_SIZE.
  - Then size 1, word 0x0000_0001: writes addr 0, acks 0xAA.
- Run and reload:
  - In S_RUN, fetch_addr=5 gives imem_addr=5, and fetch_instr follows imem_rdata one cycle later.
  - Stray rx bytes produce no write.
  - reload_req gives core_reset=1 next cycle and tx 0x99.
- Async reset mid-S_LOAD after 6 bytes:
  - Outputs return to reset values immediately.
  - No further writes; the next load starts at addr 0.
